// File: rtl/hw2_pipe_mac_if.sv
// Operand/result bus of the pipelined multiply-add unit.
// The source side drives operands and takes results; the unit sees the slave view.
interface hw2_pipe_mac_if #(
    parameter int W = 8,
    parameter int G = 4
);
    localparam int OW = 2 * W + G;

    // operand beat
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  c;
    logic [1:0]    mode;
    logic          acc_clr;

    // result beat
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] d;
    logic          sat;

    // operand source and result sink
    modport master (
        output in_valid, a, b, c, mode, acc_clr, out_ready,
        input  in_ready, out_valid, d, sat
    );

    // the multiply-add unit itself
    modport slave (
        input  in_valid, a, b, c, mode, acc_clr, out_ready,
        output in_ready, out_valid, d, sat
    );
endinterface

// File: rtl/hw2_pipe_mac.sv
// Three-stage pipelined multiply-add unit with a saturating accumulator.
//   S1 registers the operand beat, S2 holds the product, S3 holds the result.
//   One global enable stalls the whole pipe when the result is not taken.
module hw2_pipe_mac #(
    parameter int W = 8,
    parameter int G = 4
) (
    input logic          clk,
    input logic          reset,
    hw2_pipe_mac_if.slave bus
);
    localparam int OW = 2 * W + G;   // result / accumulator width
    localparam int PW = 2 * W + 1;   // widest product: (a+b)*c
    localparam int TW = OW + 1;      // accumulate sum with overflow bit

    typedef enum logic [1:0] {
        MODE_MAC         = 2'b00,    // a*b + c
        MODE_SUM_MUL     = 2'b01,    // (a+b)*c
        MODE_ACC_MUL     = 2'b10,    // acc + a*b
        MODE_ACC_SUM_MUL = 2'b11     // acc + (a+b)*c
    } mode_e;

    // ---------------------------------------------------------------
    // Pipeline state
    // ---------------------------------------------------------------
    logic          v1;
    logic [W-1:0]  a1;
    logic [W-1:0]  b1;
    logic [W-1:0]  c1;
    mode_e         mode1;
    logic          clr1;

    logic          v2;
    logic [PW-1:0] p2;
    logic [W-1:0]  c2;
    mode_e         mode2;
    logic          clr2;

    logic          out_valid_q;
    logic [OW-1:0] d_q;
    logic [OW-1:0] acc_q;
    logic          sat_q;

    // ---------------------------------------------------------------
    // Combinational nets
    // ---------------------------------------------------------------
    logic          en;
    logic [W:0]    sum1;
    logic [PW-1:0] prod1;
    logic [TW-1:0] acc_base;
    logic [TW-1:0] acc_sum;
    logic [OW-1:0] res3;
    logic [OW-1:0] acc_nxt;
    logic          sat_nxt;

    // A stage may advance whenever the output slot is free or being drained;
    // a single enable keeps all stages in lockstep so bubbles move too.
    assign en = !out_valid_q || bus.out_ready;

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.sat       = sat_q;

    // S1: capture the operand beat when it is accepted
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    // NOTE: datapath registers are reset as well because d must read 0 in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1    <= 1'b0;
            a1    <= '0;
            b1    <= '0;
            c1    <= '0;
            mode1 <= MODE_MAC;
            clr1  <= 1'b0;
        end else if (en) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                a1    <= bus.a;
                b1    <= bus.b;
                c1    <= bus.c;
                mode1 <= mode_e'(bus.mode);
                clr1  <= bus.acc_clr;
            end
        end
    end

    // S1 -> S2 arithmetic: either a*b or (a+b)*c, picked by the low mode bit
    // NOTE: every net written here gets a default first, so no path can leave a
    // value unassigned and infer a latch.
    always_comb begin
        sum1  = '0;
        prod1 = '0;
        sum1  = {1'b0, a1} + {1'b0, b1};
        if (mode1 == MODE_SUM_MUL || mode1 == MODE_ACC_SUM_MUL) begin
            prod1 = PW'(sum1) * PW'(c1);
        end else begin
            prod1 = PW'(a1) * PW'(b1);
        end
    end

    // S2: hold the product and forward c, mode and clear for the result stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2    <= 1'b0;
            p2    <= '0;
            c2    <= '0;
            mode2 <= MODE_MAC;
            clr2  <= 1'b0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                p2    <= prod1;
                c2    <= c1;
                mode2 <= mode1;
                clr2  <= clr1;
            end
        end
    end

    // S2 -> S3 result forming; the accumulate sum carries one extra bit so an
    // overflow past 2^OW-1 is seen and clamped instead of wrapping
    always_comb begin
        res3     = d_q;
        acc_nxt  = acc_q;
        sat_nxt  = sat_q;
        acc_base = clr2 ? '0 : {1'b0, acc_q};
        acc_sum  = acc_base + TW'(p2);
        unique case (mode2)
            MODE_MAC: begin
                res3 = OW'(p2) + OW'(c2);
            end
            MODE_SUM_MUL: begin
                res3 = OW'(p2);
            end
            MODE_ACC_MUL, MODE_ACC_SUM_MUL: begin
                if (acc_sum[OW]) begin
                    res3 = '1;
                end else begin
                    res3 = acc_sum[OW-1:0];
                end
                acc_nxt = res3;
                // a clearing beat restarts the flag so it reflects that beat alone
                sat_nxt = (clr2 ? 1'b0 : sat_q) | acc_sum[OW];
            end
        endcase
    end

    // S3: output register plus accumulator and sticky saturation flag;
    // acc and sat only move together with a valid beat entering S3
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
        end else if (en) begin
            out_valid_q <= v2;
            if (v2) begin
                d_q   <= res3;
                acc_q <= acc_nxt;
                sat_q <= sat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_hw2_pipe_mac.sv
// Self-checking bench for hw2_pipe_mac: directed scenarios with known results
// followed by randomized traffic with random backpressure, all results scored
// against a plain-arithmetic reference model.
module tb_hw2_pipe_mac;
    localparam int     W    = 8;
    localparam int     G    = 4;
    localparam int     OW   = 2 * W + G;
    localparam longint MAXV = (longint'(1) << OW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    hw2_pipe_mac_if #(.W(W), .G(G)) bus ();

    hw2_pipe_mac #(.W(W), .G(G)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: accumulator and sticky flag as plain integers
    // ---------------------------------------------------------------
    longint m_acc = 0;
    bit     m_sat = 1'b0;

    function automatic void model_beat(input int m, input longint a, input longint b,
                                       input longint c, input bit clr,
                                       output longint d, output bit s);
        longint term;
        longint t;
        bit     ovf;
        ovf = 1'b0;
        case (m)
            0: d = a * b + c;
            1: d = (a + b) * c;
            default: begin
                term = (m == 2) ? a * b : (a + b) * c;
                t    = (clr ? 64'sd0 : m_acc) + term;
                if (t > MAXV) begin
                    d   = MAXV;
                    ovf = 1'b1;
                end else begin
                    d = t;
                end
                m_acc = d;
                m_sat = (clr ? 1'b0 : m_sat) | ovf;
            end
        endcase
        s = m_sat;
    endfunction

    typedef struct {
        longint d;
        bit     sat;
        longint spec_d;    // -1: no fixed value to compare against
        int     spec_sat;  // -1: no fixed value to compare against
    } exp_t;

    exp_t   exp_q[$];
    longint spec_d_next   = -1;
    int     spec_sat_next = -1;
    bit     took          = 1'b0;

    // Monitor: half a cycle before each edge, score the result about to be
    // taken and model the beat about to be accepted.
    always @(negedge clk) begin : monitor
        exp_t   e;
        longint md;
        bit     ms;
        if (reset) begin
            took = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", bus.out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("d", bus.d, e.d);
                    check("sat", bus.sat, e.sat);
                    if (e.spec_d >= 0)   check("spec_d", bus.d, e.spec_d);
                    if (e.spec_sat >= 0) check("spec_sat", bus.sat, e.spec_sat);
                end
            end
            if (took) begin
                model_beat(int'(bus.mode), bus.a, bus.b, bus.c, bus.acc_clr, md, ms);
                e.d        = md;
                e.sat      = ms;
                e.spec_d   = spec_d_next;
                e.spec_sat = spec_sat_next;
                exp_q.push_back(e);
            end
        end else begin
            took = 1'b0;
        end
    end

    // align to just after a rising edge
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // offer one beat and return just after the edge that accepts it
    task automatic send(input int m, input int a, input int b, input int c, input bit clr,
                        input longint sd = -1, input int ss = -1);
        int n;
        bus.mode      = 2'(m);
        bus.a         = W'(a);
        bus.b         = W'(b);
        bus.c         = W'(c);
        bus.acc_clr   = clr;
        spec_d_next   = sd;
        spec_sat_next = ss;
        bus.in_valid  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        if (!bus.in_ready) check("send_timeout", bus.in_ready, 1'b1);
        sync();
        bus.in_valid  = 1'b0;
        spec_d_next   = -1;
        spec_sat_next = -1;
    endtask

    // let every outstanding result come out
    task automatic drain();
        int n;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        sync();
    endtask

    function automatic int pick_operand();
        case ($urandom_range(0, 3))
            0:       return 255;
            1:       return int'($urandom_range(0, 15));
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c         = '0;
        bus.mode      = '0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;

        // reset state
        #13;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_d", bus.d, 0);
        check("rst_sat", bus.sat, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        reset = 1'b1;
        sync();

        // 1: latency and back-to-back
        send(0, 1, 2, 3, 0, 5);
        @(negedge clk); check("lat_n0_valid", bus.out_valid, 1'b0);
        @(negedge clk); check("lat_n1_valid", bus.out_valid, 1'b0);
        @(negedge clk); check("lat_n2_valid", bus.out_valid, 1'b1);
        check("lat_n2_d", bus.d, 5);
        sync();
        send(0, 4, 5, 6, 0, 26);
        send(1, 10, 5, 9, 0, 135);
        @(negedge clk); check("b2b_gap_valid", bus.out_valid, 1'b0);
        @(negedge clk); check("b2b_first_valid", bus.out_valid, 1'b1);
        check("b2b_first_d", bus.d, 26);
        @(negedge clk); check("b2b_second_valid", bus.out_valid, 1'b1);
        check("b2b_second_d", bus.d, 135);
        sync();
        drain();

        // 2: extremes
        send(0, 255, 255, 255, 0, 65280);
        send(1, 255, 255, 255, 0, 130050);
        send(0, 0, 0, 0, 0, 0);
        drain();

        // 3: accumulate, with a combinational beat in between
        send(2, 1, 1, 0, 1, 1);
        send(2, 2, 2, 0, 0, 5);
        send(2, 3, 3, 0, 0, 14);
        send(2, 4, 4, 0, 0, 30);
        send(2, 5, 5, 0, 0, 55);
        send(0, 1, 2, 3, 0, 5);
        send(2, 0, 0, 0, 0, 55);
        drain();

        // 4: saturation
        send(3, 255, 255, 255, 1, 130050, 0);
        for (int k = 2; k <= 8; k++) send(3, 255, 255, 255, 0, 130050 * k, 0);
        send(3, 255, 255, 255, 0, 1048575, 1);
        send(3, 255, 255, 255, 0, 1048575, 1);
        send(3, 1, 1, 1, 1, 2, 0);
        drain();

        // 5: backpressure, with a fourth beat offered during the stall
        bus.out_ready = 1'b0;
        send(2, 1, 1, 0, 1, 1);
        send(2, 2, 2, 0, 0, 5);
        send(2, 3, 3, 0, 0, 14);
        fork
            send(2, 4, 4, 0, 0, 30);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_out_valid", bus.out_valid, 1'b1);
                    check("bp_in_ready", bus.in_ready, 1'b0);
                    check("bp_d_frozen", bus.d, 1);
                end
                sync();
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // 6: reset with beats in flight while sat is set
        send(3, 255, 255, 255, 1);
        for (int k = 0; k < 8; k++) send(3, 255, 255, 255, 0);
        send(2, 1, 1, 0, 0);
        send(2, 1, 1, 0, 0);
        send(2, 1, 1, 0, 0);
        #2;
        check("pre_rst_valid", bus.out_valid, 1'b1);
        check("pre_rst_sat", bus.sat, 1'b1);
        reset = 1'b0;
        exp_q.delete();
        m_acc = 0;
        m_sat = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_d", bus.d, 0);
        check("mid_rst_sat", bus.sat, 1'b0);
        #4;
        reset = 1'b1;
        sync();
        send(2, 2, 3, 0, 0, 6, 0);
        @(negedge clk); check("post_rst_n0_valid", bus.out_valid, 1'b0);
        @(negedge clk); check("post_rst_n1_valid", bus.out_valid, 1'b0);
        @(negedge clk); check("post_rst_n2_valid", bus.out_valid, 1'b1);
        check("post_rst_d", bus.d, 6);
        sync();
        drain();

        // randomized traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid || took) begin
                bus.in_valid = ($urandom_range(0, 2) != 0);
                bus.mode     = 2'($urandom_range(0, 3));
                bus.a        = W'(pick_operand());
                bus.b        = W'(pick_operand());
                bus.c        = W'(pick_operand());
                bus.acc_clr  = ($urandom_range(0, 7) == 0);
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
